// File: rtl/inst_mem_loader_if.sv
// ----------------------------------------------------------------------------
// inst_mem_loader_if : load-stream and fetch bundle for inst_mem_loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface inst_mem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 13
);
  logic              load_start_i;
  logic [ADDR_W-1:0] load_base_i;
  logic              load_valid_i;
  logic [DATA_W-1:0] load_data_i;
  logic              load_last_i;
  logic              load_ready_o;
  logic              load_busy_o;
  logic              load_done_o;
  logic [CNT_W-1:0]  load_cnt_o;
  logic              fetch_req_i;
  logic [ADDR_W-1:0] fetch_pc_i;
  logic              fetch_stall_i;
  logic              fetch_valid_o;
  logic [DATA_W-1:0] fetch_inst_o;
  logic              fetch_fault_o;

  modport master (
    output load_start_i, load_base_i, load_valid_i, load_data_i, load_last_i,
    output fetch_req_i, fetch_pc_i, fetch_stall_i,
    input  load_ready_o, load_busy_o, load_done_o, load_cnt_o,
    input  fetch_valid_o, fetch_inst_o, fetch_fault_o
  );

  modport slave (
    input  load_start_i, load_base_i, load_valid_i, load_data_i, load_last_i,
    input  fetch_req_i, fetch_pc_i, fetch_stall_i,
    output load_ready_o, load_busy_o, load_done_o, load_cnt_o,
    output fetch_valid_o, fetch_inst_o, fetch_fault_o
  );
endinterface

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// ----------------------------------------------------------------------------
// inst_mem_loader : instruction memory with streamed load port and 1-cycle fetch
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_mem_loader #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4096,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input wire logic          clk,
  input wire logic          rst_n,
  inst_mem_loader_if.slave  bus
);
  localparam int               AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W      = $clog2(DEPTH) + 1;
  // One spare bit so DEPTH itself is representable as a word address
  localparam int               WA_W       = ADDR_W - 1;
  localparam logic [WA_W-1:0]  DEPTH_WA   = WA_W'(DEPTH);
  localparam logic [AW-1:0]    LAST_WADDR = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [AW-1:0]     r_waddr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fvalid;
  logic              r_ffault;
  logic              r_nop_sel;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_start;
  logic              w_beat;
  logic [WA_W-1:0]   w_base_word;
  logic [WA_W-1:0]   w_base_mod;
  logic [WA_W-1:0]   w_pc_word;
  logic              w_bad;
  logic [AW-1:0]     w_ridx;
  logic              w_serve;
  logic              w_unused_bits;

  assign w_start     = (r_state != ST_LOAD) && bus.load_start_i;
  assign w_beat      = (r_state == ST_LOAD) && bus.load_valid_i;
  assign w_base_word = {1'b0, bus.load_base_i[ADDR_W-1:2]};
  assign w_base_mod  = w_base_word % DEPTH_WA;
  assign w_pc_word   = {1'b0, bus.fetch_pc_i[ADDR_W-1:2]};
  assign w_bad       = (bus.fetch_pc_i[1:0] != 2'b00) || (w_pc_word >= DEPTH_WA);
  assign w_ridx      = bus.fetch_pc_i[AW+1:2];
  assign w_serve     = bus.fetch_req_i && !bus.fetch_stall_i &&
                       (r_state != ST_LOAD) && !w_start;
  assign w_unused_bits = ^{bus.load_base_i[1:0], w_base_mod[WA_W-1:AW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_waddr <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.load_start_i) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_waddr <= w_base_mod[AW-1:0];
            r_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.load_valid_i) begin
            r_waddr <= (r_waddr == LAST_WADDR) ? '0 : r_waddr + 1'b1;
            r_cnt   <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            if (bus.load_last_i) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      mem[r_waddr] <= bus.load_data_i;
    end
  end

  // Read data kept out of the reset domain; r_nop_sel masks it until a good fetch
  always_ff @(posedge clk) begin
    if (w_serve && !w_bad) begin
      r_rdata <= mem[w_ridx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fvalid  <= 1'b0;
      r_ffault  <= 1'b0;
      r_nop_sel <= 1'b1;
    end else if ((r_state == ST_LOAD) || w_start) begin
      r_fvalid <= 1'b0;
      r_ffault <= 1'b0;
    end else if (!bus.fetch_stall_i) begin
      r_fvalid <= bus.fetch_req_i;
      r_ffault <= bus.fetch_req_i && w_bad;
      if (bus.fetch_req_i) begin
        r_nop_sel <= w_bad;
      end
    end
  end

  assign bus.load_ready_o  = (r_state == ST_LOAD);
  assign bus.load_busy_o   = r_busy;
  assign bus.load_done_o   = r_done;
  assign bus.load_cnt_o    = r_cnt;
  assign bus.fetch_valid_o = r_fvalid;
  assign bus.fetch_fault_o = r_ffault;
  assign bus.fetch_inst_o  = r_nop_sel ? NOP_INST : r_rdata;

endmodule

`default_nettype wire
